// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store front end for the byte-masked data SRAM
// Purpose: accepts one load/store per cycle from the memory stage, drives the SRAM
//   cs/we/wem/addr/din, and returns a registered, extended load result one cycle later.
// Optional macro DMEM_MISALIGN_SPLIT_EN: misaligned half/word accesses are split into two
//   SRAM cycles (SPLIT state); without it they are rejected with rsp_err.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_addr/req_we/req_size          byte address, store flag, 00=B 01=H 10/11=W
//   req_unsigned/req_wdata            zero-extend loads, right-justified store data
//   rsp_valid/rsp_rdata/rsp_err       one-cycle response pulse, load data, misaligned flag
//   ram_cs/ram_we/ram_wem/ram_addr/ram_din  SRAM controls (combinational)
//   ram_dout                          SRAM read data, combinational from ram_addr
module dmem_access_ctrl #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [3:0]    ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout
);

`ifdef DMEM_MISALIGN_SPLIT_EN
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SPLIT = 1'b1} state_t;
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0} state_t;
`endif

  state_t        r_state, w_state_nxt;
  logic          r_rsp_valid, r_rsp_err;
  logic [31:0]   r_rsp_rdata;
  logic          w_rsp_valid_nxt, w_rsp_err_nxt;
  logic [31:0]   w_rsp_rdata_nxt;
  logic          w_accept, w_misaligned;
  logic [1:0]    w_lo;
  logic [4:0]    w_sh;
  logic [3:0]    w_wem_base, w_wem_lo;
  logic [31:0]   w_din_rep, w_load_al;
  logic [AW-1:0] w_addr_word;

  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns);
    case (sz)
      2'b00:   f_extend = uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   f_extend = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: f_extend = d;
    endcase
  endfunction

  assign req_ready    = (r_state == S_IDLE);
  assign w_accept     = req_valid & req_ready;
  assign w_lo         = req_addr[1:0];
  assign w_sh         = {w_lo, 3'b000};
  assign w_addr_word  = {req_addr[AW-1:2], 2'b00};
  // Size 11 is handled exactly like a word.
  assign w_misaligned = ((req_size == 2'b01) & w_lo[0]) | (req_size[1] & (w_lo != 2'b00));

  always_comb begin
    w_wem_base = 4'hF;
    w_din_rep  = req_wdata;
    case (req_size)
      2'b00: begin
        w_wem_base = 4'b0001;
        w_din_rep  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_wem_base = 4'b0011;
        w_din_rep  = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_load_al = f_extend(ram_dout >> w_sh, req_size, req_unsigned);

`ifdef DMEM_MISALIGN_SPLIT_EN
  // The 8-bit shifted mask holds first-word lanes in [3:0] and the spill into the next
  // word in [7:4]; rotating the store data puts each byte on its final lane for both halves.
  logic [7:0]    w_wem8;
  logic [31:0]   w_din_rot, w_load_split;
  logic          r_we, r_uns;
  logic [1:0]    r_size;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_wem_hi;
  logic [31:0]   r_din, r_lo_word;

  assign w_wem8       = {4'b0000, w_wem_base} << w_lo;
  assign w_wem_lo     = w_wem8[3:0];
  assign w_din_rot    = (req_wdata << w_sh) | (req_wdata >> (6'd32 - {1'b0, w_sh}));
  assign w_load_split = 32'({ram_dout, r_lo_word} >> {r_addr[1:0], 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      r_size    <= 2'b00;
      r_addr    <= '0;
      r_wem_hi  <= 4'h0;
      r_din     <= 32'h0;
      r_lo_word <= 32'h0;
    end else if (w_accept && w_misaligned) begin
      r_we      <= req_we;
      r_uns     <= req_unsigned;
      r_size    <= req_size;
      r_addr    <= req_addr;
      r_wem_hi  <= w_wem8[7:4];
      r_din     <= w_din_rot;
      r_lo_word <= ram_dout;
    end
  end
`else
  assign w_wem_lo = w_wem_base << w_lo;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = 32'h0;
    ram_cs          = 1'b0;
    ram_we          = 1'b0;
    ram_wem         = 4'h0;
    ram_addr        = w_addr_word;
    ram_din         = w_din_rep;
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (r_state == S_SPLIT) begin
      ram_cs          = 1'b1;
      ram_we          = r_we;
      ram_wem         = r_wem_hi;
      ram_addr        = {r_addr[AW-1:2], 2'b00} + AW'(4);
      ram_din         = r_din;
      w_rsp_valid_nxt = 1'b1;
      w_rsp_rdata_nxt = r_we ? 32'h0 : f_extend(w_load_split, r_size, r_uns);
      w_state_nxt     = S_IDLE;
    end else
`endif
    if (w_accept) begin
      w_rsp_valid_nxt = 1'b1;
      if (!w_misaligned) begin
        ram_cs          = 1'b1;
        ram_we          = req_we;
        ram_wem         = w_wem_lo;
        w_rsp_rdata_nxt = req_we ? 32'h0 : w_load_al;
      end else begin
`ifdef DMEM_MISALIGN_SPLIT_EN
        ram_cs          = 1'b1;
        ram_we          = req_we;
        ram_wem         = w_wem_lo;
        ram_din         = w_din_rot;
        w_rsp_valid_nxt = 1'b0;
        w_state_nxt     = S_SPLIT;
`else
        w_rsp_err_nxt   = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl
module tb_dmem_access_ctrl;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_init = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, ram_cs, ram_we;
  logic [31:0] rsp_rdata, ram_addr, ram_din, ram_dout;
  logic [3:0]  ram_wem;
  logic [31:0] mem [0:63];
  logic [32:0] exp_q [$];
  int          n_checks = 0, n_fail = 0;

  dmem_access_ctrl #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_wem(ram_wem), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  assign ram_dout = mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | i;
    end else if (ram_cs && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_wem[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_din[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected rsp_valid", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_cs, input logic [31:0] exp_raddr,
                        input logic [3:0] exp_wem, input logic [31:0] exp_din,
                        input logic [31:0] exp_rdata, input logic exp_err, input logic push);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    chk("req_ready", {31'h0, req_ready}, 32'd1);
    chk("ram_cs", {31'h0, ram_cs}, {31'h0, exp_cs});
    if (exp_cs) begin
      chk("ram_we", {31'h0, ram_we}, {31'h0, we});
      chk("ram_addr", ram_addr, exp_raddr);
      chk("ram_wem", {28'h0, ram_wem}, {28'h0, exp_wem});
      if (we) chk("ram_din", ram_din, exp_din);
    end else begin
      chk("ram_we idle", {31'h0, ram_we}, 32'd0);
      chk("ram_wem idle", {28'h0, ram_wem}, 32'd0);
    end
    if (push) exp_q.push_back({exp_err, exp_rdata});
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

`ifdef DMEM_MISALIGN_SPLIT_EN
  task automatic split2(input logic we, input logic [31:0] exp_raddr,
                        input logic [3:0] exp_wem, input logic [31:0] exp_din);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("split req_ready", {31'h0, req_ready}, 32'd0);
    chk("split ram_cs", {31'h0, ram_cs}, 32'd1);
    chk("split ram_we", {31'h0, ram_we}, {31'h0, we});
    chk("split ram_addr", ram_addr, exp_raddr);
    chk("split ram_wem", {28'h0, ram_wem}, {28'h0, exp_wem});
    if (we) chk("split ram_din", ram_din, exp_din);
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    chk("reset rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", {31'h0, rsp_err}, 32'd0);
    chk("reset ram_cs", {31'h0, ram_cs}, 32'd0);
    chk("reset ram_we", {31'h0, ram_we}, 32'd0);
    chk("reset ram_wem", {28'h0, ram_wem}, 32'd0);
    chk("reset req_ready", {31'h0, req_ready}, 32'd1);
    rst_n = 1'b1;
    mem_init = 1'b0;
    idle_cycle();

    // we, size, uns, addr, wdata, cs, ram_addr, wem, din, rdata, err, push
    do_req(1, SW, 0, 32'h10, 32'hDEADBEEF, 1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 0, 1);
    do_req(0, SW, 0, 32'h10, 32'h0, 1, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 0, 1);
    do_req(1, SB, 0, 32'h13, 32'h80, 1, 32'h10, 4'b1000, 32'h80808080, 32'h0, 0, 1);
    do_req(0, SB, 0, 32'h13, 32'h0, 1, 32'h10, 4'b1000, 32'h0, 32'hFFFFFF80, 0, 1);
    do_req(0, SB, 1, 32'h13, 32'h0, 1, 32'h10, 4'b1000, 32'h0, 32'h00000080, 0, 1);
    do_req(1, SH, 0, 32'h22, 32'h8001, 1, 32'h20, 4'b1100, 32'h80018001, 32'h0, 0, 1);
    do_req(0, SH, 0, 32'h22, 32'h0, 1, 32'h20, 4'b1100, 32'h0, 32'hFFFF8001, 0, 1);
    do_req(0, SH, 1, 32'h22, 32'h0, 1, 32'h20, 4'b1100, 32'h0, 32'h00008001, 0, 1);
    for (int i = 0; i < 4; i++)
      do_req(0, SW, 0, 32'(4*i), 32'h0, 1, 32'(4*i), 4'hF, 32'h0, 32'hC0DE0000 | i, 0, 1);
    do_req(0, SB, 1, 32'h20, 32'h0, 1, 32'h20, 4'b0001, 32'h0, 32'h00000008, 0, 1);
    do_req(0, SR, 0, 32'h20, 32'h0, 1, 32'h20, 4'hF, 32'h0, 32'h80010008, 0, 1);
    idle_cycle();

`ifdef DMEM_MISALIGN_SPLIT_EN
    do_req(1, SW, 0, 32'h0E, 32'h11223344, 1, 32'h0C, 4'b1100, 32'h33441122, 32'h0, 0, 1);
    split2(1, 32'h10, 4'b0011, 32'h33441122);
    do_req(0, SW, 0, 32'h0E, 32'h0, 1, 32'h0C, 4'b1100, 32'h0, 32'h11223344, 0, 1);
    split2(0, 32'h10, 4'b0011, 32'h0);
    do_req(0, SH, 0, 32'hFFFFFFFF, 32'h0, 1, 32'hFFFFFFFC, 4'b1000, 32'h0, 32'h000000C0, 0, 1);
    split2(0, 32'h0, 4'b0001, 32'h0);
    do_req(1, SW, 0, 32'h2E, 32'hAABBCCDD, 1, 32'h2C, 4'b1100, 32'hCCDDAABB, 32'h0, 0, 0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("split req_ready", {31'h0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("reset mid-split ram_cs", {31'h0, ram_cs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, SW, 0, 32'h2C, 32'h0, 1, 32'h2C, 4'hF, 32'h0, 32'hCCDD000B, 0, 1);
    idle_cycle();
`else
    do_req(0, SW, 0, 32'h11, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
    do_req(1, SW, 0, 32'h12, 32'h12345678, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
    do_req(0, SW, 0, 32'h10, 32'h0, 1, 32'h10, 4'hF, 32'h0, 32'h80ADBEEF, 0, 1);
    do_req(0, SH, 1, 32'h21, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
    do_req(0, SR, 0, 32'h22, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
    do_req(0, SB, 0, 32'h21, 32'h0, 1, 32'h20, 4'b0010, 32'h0, 32'h00000000, 0, 1);
    idle_cycle();
`endif

    repeat (4) @(negedge clk);
    chk("responses outstanding", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Load/store front end that sits directly upstream of the general-purpose byte-masked data SRAM.
- Accepts one load or store per cycle from the pipeline's memory stage.
- Drives the SRAM's cs/we/wem/addr/din: word-aligned address, lane-replicated write data, byte mask.
- Returns a registered, sign/zero-extended load result (or store completion) one cycle after acceptance.
- Detects misaligned halfword/word accesses; the optional feature splits them into two SRAM cycles.

Parameters:
- AW, 32, address width in bits. Data width is fixed at 32; the byte-mask width is fixed at 4.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_addr  in  AW  byte address
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned access (only when the macro is absent)
- ram_cs  out  1  SRAM chip select
- ram_we  out  1  SRAM write enable
- ram_wem  out  4  SRAM byte-lane mask
- ram_addr  out  AW  word-aligned byte address {addr[AW-1:2],2'b00}
- ram_din  out  32  lane-positioned write data
- ram_dout  in  32  SRAM read data, combinational from ram_addr

Behaviour:
- Reset (rst_n=0, async): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, hold registers=0.
- Reset values of the ram_* outputs are combinational and equal their IDLE/no-request values: ram_cs=0, ram_we=0, ram_wem=0.
- FSM states: IDLE (ready for a request), SPLIT (second half of a misaligned access; exists only with the macro).
- req_ready = (state==IDLE). Accept cycle T = cycle with req_valid & req_ready.
- Aligned access, cycle T, combinational:
  - ram_cs=1; ram_we=req_we; ram_addr=word-aligned req_addr.
  - Byte: ram_wem = 4'b0001<<addr[1:0]; ram_din = {4{wdata[7:0]}}.
  - Half: ram_wem = 4'b0011<<addr[1:0]; ram_din = {2{wdata[15:0]}}.
  - Word: ram_wem = 4'hF; ram_din = wdata.
  - For loads, ram_wem is driven identically; the SRAM ignores it because we=0.
- Aligned load: at the T edge, register ram_dout>>(8*addr[1:0]).
  - Byte: extend bit 7; half: extend bit 15.
  - Extension is sign unless req_unsigned=1, then zero.
  - Word: passed unchanged.
- Response: rsp_valid=1 in T+1 for exactly one cycle; rsp_err=0; rsp_rdata=0 for stores.
- Back-to-back: aligned requests may be accepted every cycle; responses keep order, one per cycle.
- Misalignment: half with addr[0]=1; word with addr[1:0]!=0. Byte accesses are never misaligned.
- No request accepted: ram_cs=0, ram_we=0, ram_wem=0; ram_addr/ram_din are don't-care but must not toggle X in simulation.
- A store followed next cycle by a load to the same word must return the stored data; the SRAM write lands at the T edge.

Optional Feature:
- Macro DMEM_MISALIGN_SPLIT_EN.
- Macro absent:
  - A misaligned request is accepted in T but drives ram_cs=0; nothing is written.
  - T+1: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - The SPLIT state does not exist.
- Macro defined: misaligned access is split into two SRAM cycles, and rsp_err is tied 0.
  - Cycle T: access word A; lanes addr[1:0]..3 only.
  - T edge: latch the request and, for loads, ram_dout; state→SPLIT, so req_ready=0 in T+1.
  - Cycle T+1: access word A+4, modulo 2^AW, so 0xFFFFFFFC wraps to 0x0. Remaining lanes from lane 0; store data rotated accordingly.
  - Load result assembled from the two words, then extended as for aligned loads.
  - rsp_valid in T+2; state→IDLE at the T+1 edge; the next request can be accepted in T+2.
  - Reset during SPLIT: second half is not issued, no response; the first-half store bytes remain written.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> write cycle ram_wem=4'hF, ram_addr=0x10; load rsp_valid one cycle later, rsp_rdata=0xDEADBEEF.
- SB 0x80 @0x13, then LB and LBU @0x13 -> ram_wem=4'b1000, ram_din=0x80808080; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH 0x8001 @0x22, then LH @0x22 -> ram_wem=4'b1100; returns 0xFFFF8001; LHU @0x22 returns 0x00008001.
- Four back-to-back LW @0x0,0x4,0x8,0xC with req_valid held -> req_ready=1 throughout; four consecutive rsp_valid pulses with data in order.
- Without macro: LW @0x11 -> ram_cs=0; next cycle rsp_err=1, rsp_rdata=0; memory unchanged.
- With macro: SW 0x11223344 @0x0E, then LW @0x0E -> store uses wem 4'b1100 @0x0C then 4'b0011 @0x10; req_ready=0 in the second cycle; LW returns 0x11223344 two cycles after acceptance; assert rst_n mid-SPLIT -> no rsp_valid.
